ps2_direction_decoder: RTL and testbench
========================================

# ps2_direction_decoder

Receives PS/2 keyboard frames, decodes make/break scan codes, and drives the 4-bit one-hot direction bus consumed by the snake game's `dirIn` input. It also drives a start pulse for the title screen. It sits between the board's PS/2 pins and the game top level, and is clocked from the same 50 MHz system clock.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50_000: system clocks without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- `clk` input 1: 50 MHz system clock.
- `reset` input 1: synchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock from the pin (asynchronous).
- `ps2_dat` input 1: raw PS/2 data from the pin (asynchronous).
- `dirOut` output 4: one-hot held direction, registered.
  - Bit 3 = up, bit 2 = down, bit 1 = left, bit 0 = right.
  - 4'b0000 = no direction key held.
- `start_pulse` output 1: one-cycle pulse on a Space make code.
- `byte_valid` output 1: one-cycle pulse when a good frame is received.
- `byte_out` output 8: last good received byte. It is valid while `byte_valid` is high and holds its value afterwards.
- `frame_err` output 1: one-cycle pulse when a frame is discarded for parity, start-bit, stop-bit or timeout failure.

## Operation
- **Input synchronisation.** `ps2_clk` and `ps2_dat` each pass through a 2-flop synchroniser. A falling edge is detected as prev=1, cur=1→0 on the synchronised clock. Data is sampled on the synchronised data at the detected edge.
- **Receiver FSM** (one bit per falling edge):
  - IDLE: bit == 0 → DATA, with bit count 0. Bit == 1 is an invalid start: pulse `frame_err` and stay in IDLE.
  - DATA: shift in LSB first. After 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: the frame is good only if the stop bit == 1 and data^parity gives odd parity (XOR of all 9 bits == 1).
    - Good frame: pulse `byte_valid`, update `byte_out`, present the byte to the decoder.
    - Otherwise: pulse `frame_err`.
    - Either way → IDLE.
- **Timeout.** A counter resets on every falling edge and increments otherwise, saturating. In any state other than IDLE, reaching `TIMEOUT_CYCLES` forces IDLE and pulses `frame_err`. No byte is emitted. The counter is 16 bits wide, sufficient for the default value.
- **Scan-code decoder** (runs on each good byte):
  - E0 sets the `ext` flag. F0 sets the `brk` flag. Neither changes any output.
  - Any other byte is a key code. It is resolved using the current `ext`/`brk` flags, after which both flags clear.
  - Key map:
    - Up: E0 75 or 1D (W).
    - Down: E0 72 or 1B (S).
    - Left: E0 6B or 1C (A).
    - Right: E0 74 or 23 (D).
    - Space: 29, non-extended only.
  - A direction key with a mismatched `ext` flag is ignored. For example, bare 75 (keypad 8) is not "up".
- **Make code for a direction:** `dirOut` ← that key's one-hot value, replacing any previous value (last key wins). A typematic repeat of the same make leaves the value unchanged.
- **Break code for a direction:** clears `dirOut` to 0 only if its bit is the one currently set. A break of any other key is ignored.
- **Make code for Space:** pulses `start_pulse`. A Space break produces nothing.
- **Unmapped codes:** clear the flags only.

## Timing
- **Reset values.** All outputs are 0. The FSM is in IDLE, the flags are clear, the counters are 0, and the synchroniser flops are loaded with 1 (the bus idle level).
- **Reset is checked before all other logic.** Asserting `reset` mid-frame discards the partial byte, with no `frame_err` pulse.
- **Edge detection latency.** From a pin falling edge to the edge being detected: 3 clk (2 synchroniser + 1 edge register).
- **Stop-bit to outputs.**
  - `byte_valid`, `byte_out` and `frame_err` are asserted on the cycle after the stop-bit edge is detected.
  - `dirOut` and `start_pulse` update on the cycle after that (decoder register). This is 2 clk after the stop-bit edge detect.
- **Pulse width.** All pulse outputs are high for exactly one clk.
- **No handshake.** The consumer samples `dirOut` as a level. Bytes are never buffered: a PS/2 frame (≥ ~0.6 ms) always completes decode before the next frame can start.
- **Simultaneous events.** A timeout and a falling edge in the same cycle: the edge wins and the counter resets.

## Test plan
- **Reset.** Hold `reset`=0 for 5 clk while the PS/2 bus idles at 1 → all outputs 0. Release, then send frame 0x1D (W) → `byte_valid` pulse with `byte_out`=8'h1D, then `dirOut`=4'b1000 two clk after the stop-bit edge detect.
- **Extended make and break.**
  - Send E0 74 → `dirOut`=4'b0001.
  - Send E0 6B → `dirOut`=4'b0010.
  - Send E0 F0 74 (break right) → `dirOut` stays 4'b0010.
  - Send E0 F0 6B → `dirOut`=4'b0000.
- **Parity and stop errors.**
  - Send 0x23 with even parity → `frame_err` pulse, no `byte_valid`, `dirOut` unchanged.
  - Send 0x23 with stop bit 0 → `frame_err` pulse.
  - Then send a good 0x23 → `dirOut`=4'b0001.
- **Timeout.** With `TIMEOUT_CYCLES`=100, send a start bit plus 4 data bits, then stall 150 clk → one `frame_err` pulse and the FSM returns to IDLE. A following good frame 0x1B → `dirOut`=4'b0100.
- **Space and ignored codes.**
  - Send 29 → a single-cycle `start_pulse`.
  - Send F0 29 → no pulse.
  - Send bare 75 → `byte_valid` only, `dirOut` unchanged.
- **Repeat and mid-frame reset.**
  - Send 1C three times → `dirOut`=4'b0010 throughout.
  - Assert `reset` during bit 5 of the next frame → all outputs 0, no `frame_err`.
  - After release, a clean frame decodes correctly.

Source files
------------

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// It turns make/break codes for WASD and the arrow keys into a held one-hot
// direction for the snake game. A Space make code produces a start pulse.
module ps2_direction_decoder #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] dirOut,
  output logic       start_pulse,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  logic       clk_s1, clk_s2, clk_prev;
  logic       dat_s1, dat_s2;
  logic       fall_q;
  logic       sample_dat;
  logic [15:0] idle_cnt;
  logic       timeout_hit;

  rx_state_t  state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       parity_bit;

  logic       ext;
  logic       brk;
  logic [3:0] key_dir;
  logic       is_space;

  // Two-flop synchronisers and the falling-edge register. They idle at 1,
  // so reset cannot manufacture a false edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      fall_q     <= 1'b0;
      sample_dat <= 1'b1;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      dat_s1     <= ps2_dat;
      dat_s2     <= dat_s1;
      fall_q     <= clk_prev & ~clk_s2;
      sample_dat <= dat_s2;
    end
  end

  // Counts clocks since the last PS/2 falling edge and saturates at the top.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (fall_q) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout_hit = (idle_cnt >= TIMEOUT_LIM);

  // Frame receiver. It takes one bit per detected falling edge. An edge takes
  // priority over a timeout that occurs in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_q) begin
        case (state)
          IDLE: begin
            if (!sample_dat) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {sample_dat, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= sample_dat;
            state      <= STOP;
          end
          STOP: begin
            if (sample_dat && (^{shift_reg, parity_bit})) begin
              byte_valid <= 1'b1;
              byte_out   <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && timeout_hit) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  // Maps the current byte to a direction or to Space. Extended and plain
  // codes must match their own key. For example, keypad 8 is not up.
  always_comb begin
    key_dir  = 4'b0000;
    is_space = 1'b0;
    case (byte_out)
      8'h75: if (ext)  key_dir = DIR_UP;
      8'h1D: if (!ext) key_dir = DIR_UP;
      8'h72: if (ext)  key_dir = DIR_DOWN;
      8'h1B: if (!ext) key_dir = DIR_DOWN;
      8'h6B: if (ext)  key_dir = DIR_LEFT;
      8'h1C: if (!ext) key_dir = DIR_LEFT;
      8'h74: if (ext)  key_dir = DIR_RIGHT;
      8'h23: if (!ext) key_dir = DIR_RIGHT;
      8'h29: if (!ext) is_space = 1'b1;
      default: ;
    endcase
  end

  // Scan-code decoder. It tracks the E0/F0 prefixes and updates the held
  // direction one cycle after each good byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      dirOut      <= 4'b0000;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (byte_valid) begin
        if (byte_out == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_out == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk) begin
            if (key_dir != 4'b0000 && dirOut == key_dir) begin
              dirOut <= 4'b0000;
            end
          end else begin
            if (key_dir != 4'b0000) begin
              dirOut <= key_dir;
            end
            if (is_space) begin
              start_pulse <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed testbench for ps2_direction_decoder. It bit-bangs PS/2 frames at
// 40 system clocks per bit, with the timeout shortened to 100 clocks.
`timescale 1ns/1ps
module tb_ps2_direction_decoder;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [3:0] dirOut;
  logic       start_pulse;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       frame_err;

  int checks;
  int errors;
  int bv_count;
  int fe_count;
  int sp_count;

  ps2_direction_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .dirOut     (dirOut),
    .start_pulse(start_pulse),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .frame_err  (frame_err)
  );

  // 100 MHz bench clock. Only the cycle count matters.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts the cycles each pulse output is high. A stretched pulse therefore
  // shows up as a count above one.
  always @(posedge clk) begin
    if (byte_valid)  bv_count = bv_count + 1;
    if (frame_err)   fe_count = fe_count + 1;
    if (start_pulse) sp_count = sp_count + 1;
  end

  // Stops a runaway simulation.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 600 us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_counts();
    bv_count = 0;
    fe_count = 0;
    sp_count = 0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one bit with a 40-clock period: low phase of 20 clocks, with the
  // data set up 10 clocks before the falling edge.
  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_clks(10);
    ps2_clk = 1'b0;
    wait_clks(20);
    ps2_clk = 1'b1;
    wait_clks(10);
  endtask

  task automatic apply_frame(input logic [7:0] data, input logic bad_parity,
                             input logic stop_bit);
    logic par;
    par = (~^data) ^ bad_parity;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    send_bit(stop_bit);
    ps2_dat = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_good(input logic [7:0] data);
    apply_frame(data, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] w_code;
    checks   = 0;
    errors   = 0;
    clear_counts();
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;

    // Reset state.
    wait_clks(5);
    check_output("reset_dir", 32'(dirOut), 32'h0);
    check_output("reset_start", 32'(start_pulse), 32'h0);
    check_output("reset_valid", 32'(byte_valid), 32'h0);
    check_output("reset_byte", 32'(byte_out), 32'h0);
    check_output("reset_err", 32'(frame_err), 32'h0);
    reset = 1'b1;
    wait_clks(5);

    // W key. The stop bit is driven by hand to check exact latency.
    w_code = 8'h1D;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(w_code[i]);
    send_bit(~^w_code);
    ps2_dat = 1'b1;
    wait_clks(10);
    ps2_clk = 1'b0;
    wait_clks(3);
    check_output("w_valid_early", 32'(byte_valid), 32'h0);
    wait_clks(1);
    check_output("w_valid", 32'(byte_valid), 32'h1);
    check_output("w_byte", 32'(byte_out), 32'h1D);
    check_output("w_dir_early", 32'(dirOut), 32'h0);
    wait_clks(1);
    check_output("w_dir", 32'(dirOut), 32'h8);
    check_output("w_valid_width", 32'(byte_valid), 32'h0);
    wait_clks(15);
    ps2_clk = 1'b1;
    wait_clks(20);

    // Extended make and break.
    send_good(8'hE0); send_good(8'h74);
    check_output("ext_right", 32'(dirOut), 32'h1);
    send_good(8'hE0); send_good(8'h6B);
    check_output("ext_left", 32'(dirOut), 32'h2);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h74);
    check_output("brk_other", 32'(dirOut), 32'h2);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h6B);
    check_output("brk_left", 32'(dirOut), 32'h0);

    // Parity and stop errors.
    clear_counts();
    apply_frame(8'h23, 1'b1, 1'b1);
    check_output("par_err", 32'(fe_count), 32'd1);
    check_output("par_novalid", 32'(bv_count), 32'd0);
    check_output("par_dir", 32'(dirOut), 32'h0);
    clear_counts();
    apply_frame(8'h23, 1'b0, 1'b0);
    check_output("stop_err", 32'(fe_count), 32'd1);
    check_output("stop_novalid", 32'(bv_count), 32'd0);
    send_good(8'h23);
    check_output("d_after_err", 32'(dirOut), 32'h1);

    // Timeout after a start bit and four data bits.
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_clks(150);
    check_output("timeout_err", 32'(fe_count), 32'd1);
    check_output("timeout_novalid", 32'(bv_count), 32'd0);
    clear_counts();
    send_good(8'h1B);
    check_output("s_after_to", 32'(dirOut), 32'h4);
    check_output("s_no_err", 32'(fe_count), 32'd0);

    // Space and ignored codes.
    clear_counts();
    send_good(8'h29);
    check_output("space_pulse", 32'(sp_count), 32'd1);
    clear_counts();
    send_good(8'hF0); send_good(8'h29);
    check_output("space_break", 32'(sp_count), 32'd0);
    clear_counts();
    send_good(8'h75);
    check_output("bare75_valid", 32'(bv_count), 32'd1);
    check_output("bare75_dir", 32'(dirOut), 32'h4);

    // Typematic repeat.
    for (int k = 0; k < 3; k++) begin
      send_good(8'h1C);
      check_output("repeat_a", 32'(dirOut), 32'h2);
    end

    // Reset in the middle of bit 5.
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ps2_dat = 1'b0;
    wait_clks(10);
    ps2_clk = 1'b0;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(10);
    check_output("mid_rst_dir", 32'(dirOut), 32'h0);
    check_output("mid_rst_byte", 32'(byte_out), 32'h0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_clks(10);
    reset = 1'b1;
    wait_clks(200);
    check_output("mid_rst_noerr", 32'(fe_count), 32'd0);
    clear_counts();
    send_good(8'h23);
    check_output("post_rst_valid", 32'(bv_count), 32'd1);
    check_output("post_rst_byte", 32'(byte_out), 32'h23);
    check_output("post_rst_dir", 32'(dirOut), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
